// File: rtl/semaforo_nvias_if.sv
// rtl/semaforo_nvias_if.sv - pedestrian/flash inputs and lamp outputs of the N-approach traffic controller
//  bt        controller input   pedestrian button
//  flash     controller input   night flashing-yellow request
//  lights    controller output  3*N_WAYS lamps, approach k at [3k+2:3k] = {red,yellow,green}
//  walk      controller output  pedestrian walk lamp
//  ped_wait  controller output  pedestrian request pending
interface semaforo_nvias_if #(
    parameter int N_WAYS = 2
);
    logic                  bt;
    logic                  flash;
    logic [3*N_WAYS-1:0]   lights;
    logic                  walk;
    logic                  ped_wait;

    modport master (output bt, output flash, input lights, input walk, input ped_wait);
    modport slave  (input bt, input flash, output lights, output walk, output ped_wait);
endinterface

// File: rtl/semaforo_nvias.sv
// rtl/semaforo_nvias.sv - round-robin N-approach traffic light with pedestrian phase and night flash
//  clk   rising-edge clock
//  rst   asynchronous active-low reset
//  bus   semaforo_nvias_if.slave: bt, flash in; lights, walk, ped_wait out
module semaforo_nvias #(
    parameter int N_WAYS      = 2,
    parameter int T_GREEN     = 8,
    parameter int T_YELLOW    = 3,
    parameter int T_ALLRED    = 2,
    parameter int T_MIN_GREEN = 4,
    parameter int T_PED       = 5,
    parameter int T_FLASH     = 4
) (
    input  logic             clk,
    input  logic             rst,
    semaforo_nvias_if.slave  bus
);
    localparam int IDX_W = $clog2(N_WAYS);

    localparam logic [2:0] S_GREEN  = 3'd0;
    localparam logic [2:0] S_YELLOW = 3'd1;
    localparam logic [2:0] S_ALLRED = 3'd2;
    localparam logic [2:0] S_PED    = 3'd3;
    localparam logic [2:0] S_FLASH  = 3'd4;

    localparam logic [7:0] C_GREEN  = 8'(T_GREEN - 1);
    localparam logic [7:0] C_YELLOW = 8'(T_YELLOW - 1);
    localparam logic [7:0] C_ALLRED = 8'(T_ALLRED - 1);
    localparam logic [7:0] C_PED    = 8'(T_PED - 1);
    localparam logic [7:0] C_FLASH  = 8'(T_FLASH - 1);
    // Green shown so far is T_GREEN - cnt (current cycle included), so the
    // minimum-green condition reduces to cnt <= T_GREEN - T_MIN_GREEN.
    localparam logic [7:0] C_EARLY  = 8'(T_GREEN - T_MIN_GREEN);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_WAYS - 1);

    logic [2:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [7:0]       r_cnt;
    logic             r_ped_req;
    logic             r_flash_ph;

    logic [2:0]       w_state;
    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] w_idx_inc;
    logic [7:0]       w_cnt;
    logic             w_ped_req;
    logic             w_flash_ph;
    logic             w_enter_ped;

    assign w_idx_inc = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;

    always_comb begin
        w_state     = r_state;
        w_idx       = r_idx;
        w_cnt       = r_cnt - 8'd1;
        w_flash_ph  = r_flash_ph;
        w_enter_ped = 1'b0;
        case (r_state)
            S_GREEN: begin
                if (r_cnt == 8'd0 || (r_ped_req && r_cnt <= C_EARLY)) begin
                    w_state = S_YELLOW;
                    w_cnt   = C_YELLOW;
                end
            end
            S_YELLOW: begin
                if (r_cnt == 8'd0) begin
                    w_state = S_ALLRED;
                    w_cnt   = C_ALLRED;
                end
            end
            S_ALLRED: begin
                if (r_cnt == 8'd0) begin
                    if (bus.flash) begin
                        w_state    = S_FLASH;
                        w_cnt      = C_FLASH;
                        w_flash_ph = 1'b1;
                    end else if (r_ped_req) begin
                        w_state     = S_PED;
                        w_cnt       = C_PED;
                        w_enter_ped = 1'b1;
                    end else begin
                        w_state = S_GREEN;
                        w_cnt   = C_GREEN;
                        w_idx   = w_idx_inc;
                    end
                end
            end
            S_PED: begin
                if (r_cnt == 8'd0) begin
                    w_state = S_GREEN;
                    w_cnt   = C_GREEN;
                    w_idx   = w_idx_inc;
                end
            end
            S_FLASH: begin
                // Leaving flash takes precedence over the half-period toggle.
                if (!bus.flash) begin
                    w_state = S_ALLRED;
                    w_cnt   = C_ALLRED;
                end else if (r_cnt == 8'd0) begin
                    w_cnt      = C_FLASH;
                    w_flash_ph = ~r_flash_ph;
                end
            end
            default: begin
                w_state = S_GREEN;
                w_cnt   = C_GREEN;
                w_idx   = '0;
            end
        endcase
        // A press on the very edge that enters PED is served by that walk phase.
        w_ped_req = w_enter_ped ? 1'b0 : (r_ped_req | bus.bt);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_GREEN;
            r_idx      <= '0;
            r_cnt      <= C_GREEN;
            r_ped_req  <= 1'b0;
            r_flash_ph <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_idx      <= w_idx;
            r_cnt      <= w_cnt;
            r_ped_req  <= w_ped_req;
            r_flash_ph <= w_flash_ph;
        end
    end

    always_comb begin
        for (int k = 0; k < N_WAYS; k++) begin
            bus.lights[3*k +: 3] = 3'b100;
            case (r_state)
                S_GREEN:  if (k == int'(r_idx)) bus.lights[3*k +: 3] = 3'b001;
                S_YELLOW: if (k == int'(r_idx)) bus.lights[3*k +: 3] = 3'b010;
                S_FLASH:  bus.lights[3*k +: 3] = {1'b0, r_flash_ph, 1'b0};
                default:  bus.lights[3*k +: 3] = 3'b100;
            endcase
        end
    end

    assign bus.walk     = (r_state == S_PED);
    assign bus.ped_wait = r_ped_req;
endmodule

// File: tb/tb_semaforo_nvias.sv
// tb/tb_semaforo_nvias.sv - scoreboard bench for semaforo_nvias (2-way and 4-way instances)
module tb_semaforo_nvias;
    localparam int P_G  = 0;
    localparam int P_Y  = 1;
    localparam int P_AR = 2;
    localparam int P_PD = 3;
    localparam int P_FL = 4;
    localparam int MAXC = 128;

    typedef struct packed {
        logic [23:0] lights;
        logic        walk;
        logic        pw;
    } exp_t;

    logic clk;
    logic rst_n;

    semaforo_nvias_if #(.N_WAYS(2)) bus2 ();
    semaforo_nvias_if #(.N_WAYS(4)) bus4 ();

    semaforo_nvias #(.N_WAYS(2)) dut2 (.clk(clk), .rst(rst_n), .bus(bus2.slave));
    semaforo_nvias #(.N_WAYS(4)) dut4 (.clk(clk), .rst(rst_n), .bus(bus4.slave));

    exp_t sb_q[$];
    bit   bt_s  [MAXC];
    bit   fl_s  [MAXC];
    bit   rlo_s [MAXC];
    int   n_checks;
    int   n_pass;
    int   tnum;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [23:0] mk_lights(input int nw, input int ph, input int a, input bit fph);
        logic [23:0] v;
        v = '0;
        for (int k = 0; k < nw; k++) begin
            case (ph)
                P_G:     v[3*k +: 3] = (k == a) ? 3'b001 : 3'b100;
                P_Y:     v[3*k +: 3] = (k == a) ? 3'b010 : 3'b100;
                P_FL:    v[3*k +: 3] = {1'b0, fph, 1'b0};
                default: v[3*k +: 3] = 3'b100;
            endcase
        end
        return v;
    endfunction

    task automatic push(input int nw, input int ph, input int a, input int n,
                        input bit walk, input bit pw, input bit fph);
        exp_t e;
        e.lights = mk_lights(nw, ph, a, fph);
        e.walk   = walk;
        e.pw     = pw;
        for (int i = 0; i < n; i++) sb_q.push_back(e);
    endtask

    // Cycle 0 is held in reset; its expected entry is the reset state.
    task automatic begin_test(input int t, input int nw);
        tnum = t;
        sb_q.delete();
        for (int i = 0; i < MAXC; i++) begin
            bt_s[i]  = 1'b0;
            fl_s[i]  = 1'b0;
            rlo_s[i] = 1'b0;
        end
        push(nw, P_G, 0, 1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run(input int ncyc, input bit use4);
        logic [23:0] obs;
        logic        ow;
        logic        op;
        exp_t        e;
        int          nw;
        nw = use4 ? 4 : 2;
        for (int c = 0; c <= ncyc; c++) begin
            rst_n      = (c == 0) ? 1'b0 : !rlo_s[c];
            bus2.bt    = bt_s[c];
            bus2.flash = fl_s[c];
            bus4.bt    = bt_s[c];
            bus4.flash = fl_s[c];
            @(negedge clk);
            if (use4) begin
                obs = 24'(bus4.lights);
                ow  = bus4.walk;
                op  = bus4.ped_wait;
            end else begin
                obs = 24'(bus2.lights);
                ow  = bus2.walk;
                op  = bus2.ped_wait;
            end
            if (sb_q.size() == 0) begin
                check_eq($sformatf("t%0d c%0d sb_empty", tnum, c), 32'd0, 32'd1);
            end else begin
                e = sb_q.pop_front();
                check_eq($sformatf("t%0d c%0d lights", tnum, c), 32'(obs), 32'(e.lights));
                check_eq($sformatf("t%0d c%0d walk", tnum, c), 32'(ow), 32'(e.walk));
                check_eq($sformatf("t%0d c%0d ped_wait", tnum, c), 32'(op), 32'(e.pw));
            end
            for (int k = 0; k < nw; k++)
                check_eq($sformatf("t%0d c%0d onehot%0d", tnum, c, k),
                         32'($countones(obs[3*k +: 3]) <= 1), 32'd1);
            @(posedge clk);
            #1;
        end
        check_eq($sformatf("t%0d sb_drain", tnum), 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        rst_n      = 1'b0;
        bus2.bt    = 1'b0;
        bus2.flash = 1'b0;
        bus4.bt    = 1'b0;
        bus4.flash = 1'b0;
        @(posedge clk);
        #1;

        // 1: free-running, two full 26-cycle periods
        begin_test(1, 2);
        for (int r = 0; r < 2; r++)
            for (int a = 0; a < 2; a++) begin
                push(2, P_G,  a, 8, 0, 0, 0);
                push(2, P_Y,  a, 3, 0, 0, 0);
                push(2, P_AR, a, 2, 0, 0, 0);
            end
        run(52, 1'b0);

        // 2: press in c2 cuts green after 4 cycles
        begin_test(2, 2);
        bt_s[2] = 1'b1;
        push(2, P_G,  0, 2, 0, 0, 0);
        push(2, P_G,  0, 2, 0, 1, 0);
        push(2, P_Y,  0, 3, 0, 1, 0);
        push(2, P_AR, 0, 2, 0, 1, 0);
        push(2, P_PD, 0, 5, 1, 0, 0);
        push(2, P_G,  1, 8, 0, 0, 0);
        run(22, 1'b0);

        // 3: press during yellow, no shortening
        begin_test(3, 2);
        bt_s[10] = 1'b1;
        push(2, P_G,  0, 8, 0, 0, 0);
        push(2, P_Y,  0, 2, 0, 0, 0);
        push(2, P_Y,  0, 1, 0, 1, 0);
        push(2, P_AR, 0, 2, 0, 1, 0);
        push(2, P_PD, 0, 5, 1, 0, 0);
        push(2, P_G,  1, 8, 0, 0, 0);
        run(26, 1'b0);

        // 4: night flash c5..c40
        begin_test(4, 2);
        for (int c = 5; c <= 40; c++) fl_s[c] = 1'b1;
        push(2, P_G,  0, 8, 0, 0, 0);
        push(2, P_Y,  0, 3, 0, 0, 0);
        push(2, P_AR, 0, 2, 0, 0, 0);
        for (int h = 0; h < 7; h++) push(2, P_FL, 0, 4, 0, 0, ((h % 2) == 0));
        push(2, P_AR, 0, 2, 0, 0, 0);
        push(2, P_G,  1, 8, 0, 0, 0);
        run(51, 1'b0);

        // 5: reset asserted in c12, mid walk phase
        begin_test(5, 2);
        bt_s[2]   = 1'b1;
        rlo_s[12] = 1'b1;
        push(2, P_G,  0, 2, 0, 0, 0);
        push(2, P_G,  0, 2, 0, 1, 0);
        push(2, P_Y,  0, 3, 0, 1, 0);
        push(2, P_AR, 0, 2, 0, 1, 0);
        push(2, P_PD, 0, 2, 1, 0, 0);
        push(2, P_G,  0, 1, 0, 0, 0);
        push(2, P_G,  0, 8, 0, 0, 0);
        push(2, P_Y,  0, 3, 0, 0, 0);
        push(2, P_AR, 0, 2, 0, 0, 0);
        push(2, P_G,  1, 1, 0, 0, 0);
        run(26, 1'b0);

        // 6: four approaches rotate 0,1,2,3,0
        begin_test(6, 4);
        for (int a = 0; a < 4; a++) begin
            push(4, P_G,  a, 8, 0, 0, 0);
            push(4, P_Y,  a, 3, 0, 0, 0);
            push(4, P_AR, a, 2, 0, 0, 0);
        end
        push(4, P_G, 0, 8, 0, 0, 0);
        run(60, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
